core_multicycle: RTL and testbench
==================================

Name: core_multicycle

Overview:
- Parametrised multi-cycle RV32I core. It is the successor to the team's single-cycle core.
- Instruction fetch and data access are time-multiplexed onto one shared memory port. The port uses a req/ack handshake, so memories may be slow.
- Adds the following, none of which the single-cycle core has: configurable register count, optional sub-word loads/stores, a retired-instruction counter, and a halting trap on illegal or misaligned operations.
- Intended as the SoC top-level CPU in front of a shared BRAM or bus arbiter.

Parameters:
- BOOT_ADDRESS, 32'h00000000: PC value after reset.
- NUM_REGS, 32: architectural register count, 32 (RV32I) or 16 (RV32E).
- SUPPORT_SUBWORD, 1: 1 implements LB/LH/LBU/LHU/SB/SH; 0 makes them illegal.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-low reset.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  byte address, always word-aligned (bits[1:0]=0).
- mem_wdata  out  32  write data, lane-aligned.
- mem_wstrb  out  4  byte enables for writes; 0000 on reads.
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  transfer completes on a rising edge where mem_req=1 and mem_ack=1.
- pc  out  32  current instruction address.
- halted  out  1  trap taken; core frozen.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset (reset=0 at a rising edge):
  - pc=BOOT_ADDRESS, state=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - halted=0, instret=0, all registers cleared to 0.
  - Reset during an outstanding request drops mem_req the next cycle. No completion is recorded.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On ack, latch IR=mem_rdata and go to DECODE.
  - Outputs are stable while waiting for ack.
- DECODE:
  - Read rs1/rs2 and generate the immediate (I/S/B/U/J formats).
  - Check legality. Illegal cases: unknown opcode/funct; rs1/rs2/rd >= NUM_REGS; a sub-word op with SUPPORT_SUBWORD=0.
  - Illegal goes to TRAP; legal goes to EXECUTE.
- EXECUTE:
  - ALU result (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, plus immediate forms). Shift amount = operand[4:0].
  - Effective address for loads/stores.
  - Branch decision for BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Next PC: pc+4, pc+imm (branch taken, JAL), or (rs1+imm)&~1 (JALR).
  - A next PC with bit 1 set goes to TRAP.
  - A misaligned effective address goes to TRAP: halfword with addr[0]=1, word with addr[1:0]!=0.
  - Load/store goes to MEMORY; everything else goes to WRITEBACK.
- MEMORY:
  - mem_req=1, mem_addr={ea[31:2],2'b00}, mem_we=1 for stores.
  - SB: wstrb=0001<<ea[1:0], data replicated to all byte lanes.
  - SH: wstrb=0011<<ea[1:0], halfword replicated.
  - SW: wstrb=1111.
  - Load data is extracted and sign/zero-extended by funct3 and ea[1:0].
  - Goes to WRITEBACK on ack.
- WRITEBACK:
  - Write rd if rd!=0 and the op writes a register. LUI=imm; AUIPC=pc+imm; JAL/JALR=pc+4.
  - Update pc, increment instret (wraps at 2^32), go to FETCH.
- Register x0 reads 0 always; writes to x0 are ignored.
- TRAP:
  - halted=1, mem_req=0, pc holds the faulting instruction address, instret is frozen.
  - Only reset exits TRAP.
- Latency with mem_ack tied to 1:
  - ALU, branch, jump, LUI, AUIPC: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1 cycle.
- mem_ack while mem_req=0 is ignored.
- FENCE executes as a NOP. ECALL/EBREAK trap.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2 with ack=1 -> x3=7, instret=3 at cycle 12, pc=0x0C.
- SW x3,8(x0) then LW x4,8(x0) with ack delayed 3 cycles -> write wstrb=1111 addr=0x08 data=7; x4=7. Each access holds req/addr stable through the waits.
- SB x5,0x11(x0) with x5=0x80, then LB and LBU from 0x11 -> wstrb=0010, wdata=0x80808080; LB=0xFFFFFF80, LBU=0x00000080.
- BNE x1,x0,-8 taken at pc=0x20 -> pc=0x18. JALR x1,x2,3 with x2=0x100 -> pc=0x102, which has bit 1 set, so TRAP with halted=1 and pc=address of the JALR.
- NUM_REGS=16: ADD x20,x1,x2 -> halted=1 and no register write. Pulse reset=0 while a fetch is stalled -> mem_req=0 next cycle, pc=BOOT_ADDRESS, instret=0.
- Opcode 0x00000000 (illegal) -> TRAP after DECODE; mem_req stays 0 afterwards despite mem_ack=1 being held.

Source files
------------

// File: rtl/core_multicycle.sv
// core_multicycle: multi-cycle RV32I/RV32E core with one shared req/ack memory port.
// Instruction fetch and load/store are time-multiplexed on the same port.
// Ports:
//   clk, reset (synchronous, active low)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : request side, held until mem_ack
//   mem_rdata/mem_ack                            : response, sampled on the acking edge
//   pc       : address of the instruction in flight (faulting address once halted)
//   halted   : trap taken, core frozen until reset
//   instret  : retired-instruction count
module core_multicycle #(
  parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
  parameter int          NUM_REGS        = 32,
  parameter bit          SUPPORT_SUBWORD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] instret
);
  localparam int RW = $clog2(NUM_REGS);

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13,
                         OP_REG = 7'h33, OP_FENCE = 7'h0f;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  state_t state, state_n;

  logic [31:0] ir, rs1v, rs2v, imm, res, npc;
  logic [1:0]  ea_lo;
  logic [31:0] regs [NUM_REGS];

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  // ---------------- decode ----------------
  logic        legal, use_rs1, use_rs2, use_rd, reg_bad, wr_rd;
  logic [31:0] imm_d, rs1_rd, rs2_rd;
  always_comb begin
    legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    imm_d = {{20{ir[31]}}, ir[31:20]};
    case (opc)
      OP_LUI, OP_AUIPC: begin legal = 1'b1; use_rd = 1'b1; imm_d = {ir[31:12], 12'b0}; end
      OP_JAL: begin
        legal = 1'b1; use_rd = 1'b1;
        imm_d = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OP_JALR: begin legal = (f3 == 3'd0); use_rs1 = 1'b1; use_rd = 1'b1; end
      OP_BR: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_d = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OP_LD: begin
        legal = (f3 == 3'd2) || (SUPPORT_SUBWORD &&
                (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5));
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_ST: begin
        legal = (f3 == 3'd2) || (SUPPORT_SUBWORD && (f3 == 3'd0 || f3 == 3'd1));
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_IMM: begin
        // shift-immediates carry funct7 in the upper immediate bits
        legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_REG: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_FENCE: legal = 1'b1;
      default:  legal = 1'b0;   // includes ECALL/EBREAK
    endcase
  end

  assign reg_bad = (use_rs1 && 32'(rs1) >= 32'(NUM_REGS)) ||
                   (use_rs2 && 32'(rs2) >= 32'(NUM_REGS)) ||
                   (use_rd  && 32'(rd)  >= 32'(NUM_REGS));
  assign wr_rd   = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL) || (opc == OP_JALR) ||
                   (opc == OP_LD)  || (opc == OP_IMM)   || (opc == OP_REG);
  assign rs1_rd  = (rs1 == 5'd0) ? 32'd0 : regs[rs1[RW-1:0]];
  assign rs2_rd  = (rs2 == 5'd0) ? 32'd0 : regs[rs2[RW-1:0]];

  // ---------------- execute ----------------
  logic [31:0] op_b, alu, sum_pc, pc4, ea, npc_x, res_x, st_data;
  logic [3:0]  st_strb;
  logic [4:0]  sh;
  logic        take, is_ld, is_st, mis;
  always_comb begin
    is_ld  = (opc == OP_LD);
    is_st  = (opc == OP_ST);
    op_b   = (opc == OP_REG) ? rs2v : imm;
    sh     = op_b[4:0];
    sum_pc = pc + imm;
    pc4    = pc + 32'd4;
    ea     = rs1v + imm;
    case (f3)
      3'd0:    alu = (opc == OP_REG && ir[30]) ? rs1v - op_b : rs1v + op_b;
      3'd1:    alu = rs1v << sh;
      3'd2:    alu = {31'b0, $signed(rs1v) < $signed(op_b)};
      3'd3:    alu = {31'b0, rs1v < op_b};
      3'd4:    alu = rs1v ^ op_b;
      3'd5:    alu = ir[30] ? 32'($signed(rs1v) >>> sh) : rs1v >> sh;
      3'd6:    alu = rs1v | op_b;
      default: alu = rs1v & op_b;
    endcase
    case (f3)
      3'd0:    take = (rs1v == rs2v);
      3'd1:    take = (rs1v != rs2v);
      3'd4:    take = $signed(rs1v) <  $signed(rs2v);
      3'd5:    take = $signed(rs1v) >= $signed(rs2v);
      3'd6:    take = rs1v <  rs2v;
      3'd7:    take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
    npc_x = pc4;
    if (opc == OP_JAL || (opc == OP_BR && take)) npc_x = sum_pc;
    if (opc == OP_JALR) npc_x = (rs1v + imm) & ~32'd1;
    case (opc)
      OP_LUI:          res_x = imm;
      OP_AUIPC:        res_x = sum_pc;
      OP_JAL, OP_JALR: res_x = pc4;
      default:         res_x = alu;
    endcase
    mis = (is_ld || is_st) &&
          ((f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00));
    // sub-word stores replicate the datum across lanes; the strobe picks the lane
    case (f3[1:0])
      2'b00:   begin st_data = {4{rs2v[7:0]}};  st_strb = 4'b0001 << ea[1:0]; end
      2'b01:   begin st_data = {2{rs2v[15:0]}}; st_strb = 4'b0011 << ea[1:0]; end
      default: begin st_data = rs2v;            st_strb = 4'b1111;            end
    endcase
  end

  // ---------------- load extraction ----------------
  logic [31:0] lsh, ld_val;
  always_comb begin
    lsh = mem_rdata >> {ea_lo, 3'b000};
    case (f3)
      3'd0:    ld_val = {{24{lsh[7]}}, lsh[7:0]};
      3'd1:    ld_val = {{16{lsh[15]}}, lsh[15:0]};
      3'd4:    ld_val = {24'b0, lsh[7:0]};
      3'd5:    ld_val = {16'b0, lsh[15:0]};
      default: ld_val = lsh;
    endcase
  end

  // ---------------- next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (mem_req && mem_ack) state_n = S_DECODE;
      S_DECODE: state_n = (legal && !reg_bad) ? S_EXEC : S_TRAP;
      S_EXEC:   state_n = (npc_x[1] || mis) ? S_TRAP : (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:    if (mem_req && mem_ack) state_n = S_WB;
      S_WB:     state_n = S_FETCH;
      default:  state_n = S_TRAP;
    endcase
  end

  assign halted = (state == S_TRAP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH; pc <= BOOT_ADDRESS; instret <= '0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0; mem_wstrb <= '0;
      ir <= '0; rs1v <= '0; rs2v <= '0; imm <= '0; res <= '0; npc <= '0; ea_lo <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_FETCH: begin
          // the fetch request is normally issued by writeback; only the first
          // fetch after reset has to raise it here
          if (!mem_req) begin
            mem_req <= 1'b1; mem_addr <= pc;
          end else if (mem_ack) begin
            ir <= mem_rdata; mem_req <= 1'b0;
          end
        end
        S_DECODE: begin rs1v <= rs1_rd; rs2v <= rs2_rd; imm <= imm_d; end
        S_EXEC: begin
          res <= res_x; npc <= npc_x; ea_lo <= ea[1:0];
          if (state_n == S_MEM) begin
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_addr  <= {ea[31:2], 2'b00};
            mem_wdata <= st_data;
            mem_wstrb <= is_st ? st_strb : 4'b0000;
          end
        end
        S_MEM: if (mem_ack) begin
          mem_req <= 1'b0; mem_we <= 1'b0; mem_wstrb <= 4'b0000;
          if (is_ld) res <= ld_val;
        end
        S_WB: begin
          if (wr_rd && rd != 5'd0) regs[rd[RW-1:0]] <= res;
          pc <= npc; instret <= instret + 32'd1;
          mem_req <= 1'b1; mem_addr <= npc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_core_multicycle.sv
module tb_core_multicycle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instret;
  logic [3:0]  mem_wstrb;

  logic        req16, we16, halted16;
  logic [31:0] addr16, wdata16, rdata16, pc16, instret16;
  logic [3:0]  wstrb16;

  core_multicycle dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .halted(halted), .instret(instret));

  core_multicycle #(.NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_wstrb(wstrb16), .mem_rdata(rdata16), .mem_ack(1'b1),
    .pc(pc16), .halted(halted16), .instret(instret16));

  // RV32E core: ADDI x1,x0,3 then ADD x20,x1,x2 (x20 does not exist)
  assign rdata16 = (addr16 == 32'h0) ? 32'h0030_0093 :
                   (addr16 == 32'h4) ? 32'h0020_8A33 : 32'h0000_0013;

  // shared memory model with programmable ack delay
  logic [31:0] mem [256];
  int          ack_dly = 0;
  int          cnt = 0;
  logic        force_ack = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_a = '0;
  logic [31:0] ld_d = '0;

  assign mem_ack   = force_ack || (mem_req && cnt >= ack_dly);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_req && mem_ack && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (!mem_req || mem_ack) cnt <= 0; else cnt <= cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] es(input logic [2:0] f3, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] eb(input logic [2:0] f3, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = a[9:2]; ld_d = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_xfer(input logic we, input logic [31:0] a, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (mem_req && mem_we == we && mem_addr == a) ok = 1'b1;
    end
  endtask

  task automatic wait_halt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (halted) ok = 1'b1;
    end
  endtask

  // find a transfer, check its fields, then check it is held steady until ack
  task automatic watch_xfer(input logic we, input logic [31:0] a, input logic [3:0] strb,
                            input logic [31:0] d, input string tag);
    logic ok;
    int   waits;
    wait_xfer(we, a, ok);
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk({tag, "_strb"}, 32'(mem_wstrb), 32'(strb));
    if (we) chk({tag, "_wdata"}, mem_wdata, d);
    waits = 0;
    while (!mem_ack && waits < 20) begin
      @(negedge clk);
      waits++;
      chk({tag, "_hold_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_hold_addr"}, mem_addr, a);
    end
    chk({tag, "_waits"}, 32'(waits), 32'd3);
  endtask

  logic ok;

  initial begin
    reset = 1'b0;
    // ---- program 1: ALU, word and byte load/store, ECALL ----
    load(32'h00, ei(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));       // ADDI x1,x0,5
    load(32'h04, ei(7'h13, 3'd0, 5'd2, 5'd1, 12'hFF9));     // ADDI x2,x1,-7
    load(32'h08, er(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));        // SUB  x3,x1,x2
    load(32'h0C, es(3'd2, 5'd0, 5'd3, 12'h008));            // SW   x3,8(x0)
    load(32'h10, ei(7'h03, 3'd2, 5'd4, 5'd0, 12'h008));     // LW   x4,8(x0)
    load(32'h14, ei(7'h13, 3'd0, 5'd5, 5'd0, 12'h080));     // ADDI x5,x0,0x80
    load(32'h18, es(3'd0, 5'd0, 5'd5, 12'h011));            // SB   x5,0x11(x0)
    load(32'h1C, ei(7'h03, 3'd0, 5'd6, 5'd0, 12'h011));     // LB   x6,0x11(x0)
    load(32'h20, ei(7'h03, 3'd4, 5'd7, 5'd0, 12'h011));     // LBU  x7,0x11(x0)
    load(32'h24, es(3'd2, 5'd0, 5'd4, 12'h040));            // SW   x4,0x40(x0)
    load(32'h28, es(3'd2, 5'd0, 5'd6, 12'h044));            // SW   x6,0x44(x0)
    load(32'h2C, es(3'd2, 5'd0, 5'd7, 12'h048));            // SW   x7,0x48(x0)
    load(32'h30, 32'h0000_0073);                            // ECALL
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instret", instret, 32'd0);
    reset = 1'b1;

    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (mem_req) ok = 1'b1;
    end
    chk("first_fetch_seen", 32'(ok), 32'd1);
    chk("first_fetch_addr", mem_addr, 32'h0);
    repeat (11) @(negedge clk);
    chk("alu_instret_c11", instret, 32'd2);
    @(negedge clk);
    chk("alu_instret_c12", instret, 32'd3);
    chk("alu_pc_c12", pc, 32'h0C);

    ack_dly = 3;
    watch_xfer(1'b1, 32'h08, 4'b1111, 32'd7, "sw");
    watch_xfer(1'b0, 32'h08, 4'b0000, 32'd0, "lw");
    watch_xfer(1'b1, 32'h10, 4'b0010, 32'h8080_8080, "sb");
    wait_halt(ok);
    chk("p1_halt_seen", 32'(ok), 32'd1);
    chk("ecall_pc", pc, 32'h30);
    chk("p1_instret", instret, 32'd12);
    chk("p1_req_idle", 32'(mem_req), 32'd0);
    chk("sw_word", mem[2], 32'd7);
    chk("sb_lane_only", mem[4], 32'h0080_8003);
    chk("lw_value", mem[16], 32'd7);
    chk("lb_value", mem[17], 32'hFFFF_FF80);
    chk("lbu_value", mem[18], 32'h0000_0080);

    // ---- program 2: JAL, taken BNE, misaligned JALR target ----
    reset = 1'b0;
    ack_dly = 0;
    load(32'h00, ei(7'h13, 3'd0, 5'd1, 5'd0, 12'd1));       // ADDI x1,x0,1
    load(32'h04, ej(5'd0, 21'h1C));                         // JAL  x0,+0x1C -> 0x20
    for (int a = 8; a < 24; a += 4) load(32'(a), 32'h0000_0013);
    load(32'h18, ei(7'h13, 3'd0, 5'd2, 5'd0, 12'h100));     // ADDI x2,x0,0x100
    load(32'h1C, ei(7'h67, 3'd0, 5'd1, 5'd2, 12'd3));       // JALR x1,x2,3
    load(32'h20, eb(3'd1, 5'd1, 5'd0, 13'h1FF8));           // BNE  x1,x0,-8
    @(negedge clk);
    chk("rst2_pc", pc, 32'h0);
    reset = 1'b1;
    wait_xfer(1'b0, 32'h20, ok);
    chk("jal_target_fetch", 32'(ok), 32'd1);
    wait_xfer(1'b0, 32'h18, ok);
    chk("bne_target_fetch", 32'(ok), 32'd1);
    chk("bne_pc", pc, 32'h18);
    wait_halt(ok);
    chk("jalr_halt_seen", 32'(ok), 32'd1);
    chk("jalr_trap_pc", pc, 32'h1C);
    chk("jalr_instret", instret, 32'd4);

    // ---- reset while a fetch is stalled ----
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (instret == 32'd2) ok = 1'b1;
    end
    ack_dly = 200;
    chk("stall_reach", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    chk("stall_req", 32'(mem_req), 32'd1);
    chk("stall_addr", mem_addr, 32'h20);
    chk("stall_pc", pc, 32'h20);
    reset = 1'b0;
    @(negedge clk);
    chk("stall_rst_req", 32'(mem_req), 32'd0);
    chk("stall_rst_pc", pc, 32'h0);
    chk("stall_rst_instret", instret, 32'd0);
    ack_dly = 0;

    // ---- illegal all-zero opcode with ack held high ----
    load(32'h00, 32'h0000_0000);
    force_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ill_fetch_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("ill_decode_not_halted", 32'(halted), 32'd0);
    @(negedge clk);
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_pc", pc, 32'h0);
    chk("ill_instret", instret, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ill_req_quiet", 32'(mem_req), 32'd0);
    end
    chk("ill_still_halted", 32'(halted), 32'd1);

    // ---- RV32E core rejected x20 ----
    chk("rv32e_halted", 32'(halted16), 32'd1);
    chk("rv32e_pc", pc16, 32'h4);
    chk("rv32e_instret", instret16, 32'd1);
    chk("rv32e_req", 32'(req16), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
